fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset.
REQ-002 Parameter BUF_DEPTH, default 2, SHALL be the instruction-buffer depth; only 2 is supported.
REQ-003 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 imem_req  out  1  fetch request, held until granted.
REQ-006 imem_addr  out  32  word-aligned fetch address, valid while imem_req=1.
REQ-007 imem_gnt  in  1  request accepted this cycle.
REQ-008 imem_rvalid  in  1  read data valid; arrives at least 1 cycle after imem_gnt.
REQ-009 imem_rdata  in  32  fetched instruction.
REQ-010 redirect  in  1  branch/jal/jalr taken; flush and refetch.
REQ-011 redirect_pc  in  32  new fetch target.
REQ-012 id_valid  out  1  buffer head holds a valid instruction.
REQ-013 id_ready  in  1  decode accepts the head this cycle.
REQ-014 id_instr  out  32  instruction to the control unit and decoder.
REQ-015 id_pc  out  32  PC of id_instr.

Function
REQ-016 At most one imem request SHALL be outstanding, counted from grant until rvalid.
REQ-017 The FSM SHALL have four states: IDLE, REQ, WAIT and DROP.
REQ-018 IDLE: the FSM SHALL go to REQ next cycle when buf_count<2 and redirect=0; otherwise it stays in IDLE.
REQ-019 REQ: imem_req=1 and imem_addr=pc; on imem_gnt the FSM SHALL go to WAIT, latch req_pc=pc and set pc<=pc+4 (mod 2^32).
REQ-020 WAIT: on imem_rvalid the FSM SHALL push {imem_rdata, req_pc} into the buffer and go to IDLE.
REQ-021 Redirect in WAIT without rvalid SHALL go to DROP; in DROP the next rvalid SHALL be discarded and the FSM SHALL return to IDLE.
REQ-022 Redirect in the same cycle as rvalid SHALL discard the response and go to IDLE.
REQ-023 Redirect in REQ SHALL win over imem_gnt: the request is treated as not granted, imem_req deasserts next cycle, and the FSM goes to IDLE.
REQ-024 Any redirect SHALL set pc<={redirect_pc[31:2],2'b00} and flush the buffer to count 0.
REQ-025 Any redirect SHALL force id_valid=0 in the following cycle.
REQ-026 Redirect SHALL take priority over a simultaneous pop (id_valid & id_ready) and a simultaneous push.
REQ-027 Buffer: a 2-entry FIFO; the head drives id_instr and id_pc; id_valid = (count!=0).
REQ-028 Buffer pop SHALL occur when id_valid & id_ready; simultaneous push and pop SHALL leave count unchanged.
REQ-029 With id_ready=0 the head SHALL hold stable, and no push SHALL occur when count=2; REQ-018 guarantees this.
REQ-030 When id_valid=0, id_instr SHALL be 32'h0000_0013 (ADDI x0,x0,0) and id_pc SHALL be 0.
REQ-031 Latency: rvalid in cycle N SHALL give id_valid=1 in N+1.
REQ-032 Throughput: with 1-cycle grant and rvalid, one instruction SHALL be delivered every 3 cycles.
REQ-033 imem_rvalid in IDLE or REQ SHALL be ignored.

Reset
REQ-034 While rst_n=0: state=IDLE, pc=RESET_PC, req_pc=0, buffer count and pointers 0, imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=32'h0000_0013, id_pc=0.
REQ-035 Assertion of rst_n mid-transaction SHALL abandon any outstanding request; an rvalid after release SHALL then be discarded as in IDLE.
REQ-036 imem_req SHALL first assert in the second rising edge after rst_n deasserts (IDLE, then REQ).

Structure
REQ-037 Shared package riscv_pkg SHALL hold: the NOP_INSTR constant 32'h0000_0013, the fetch FSM state encoding, and XLEN=32.
REQ-038 The buffer SHALL be the sub-module instr_fifo (width 64, depth 2, push/pop/flush, count output).

Verification
REQ-039 Reset release, grant immediate, rvalid next cycle with rdata=32'h00500093 -> id_valid=1, id_instr=32'h00500093, id_pc=RESET_PC.
REQ-040 id_ready=0 for 10 cycles -> exactly 2 instructions (pc 0, 4) buffered, imem_req stays 0, and the head is stable.
REQ-041 Redirect to 32'h0000_0102 during WAIT -> next rvalid discarded, next imem_addr=32'h0000_0100, and id_valid=0 the cycle after the redirect.
REQ-042 Redirect, rvalid and pop in the same cycle -> buffer empty, the response is not delivered, and pc=redirect target.
REQ-043 rst_n pulsed low while in WAIT -> all outputs at reset values, and the stale rvalid after release is ignored.
REQ-044 Streaming with id_ready=1 for 100 instructions -> id_pc increments by 4 with no gaps or duplicates.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V front end.
// Holds fetch FSM encoding, buffer entry layout and common constants.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(
        input logic [XLEN-1:0] a
    );
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small instruction buffer between fetch and decode.
// Flush has priority over push and pop; head is read combinationally.
module instr_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(
        input logic [PW-1:0] p
    );
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, 2-entry buffer to decode.
// Redirects flush the buffer and squash any response still in flight.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  req_pc_q;
    logic [31:0]  req_pc_d;
    logic         buf_push;
    logic         buf_pop;
    logic [CW-1:0] buf_count;
    fetch_entry_t push_entry;
    fetch_entry_t head;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        buf_push = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!redirect && (buf_count < CW'(BUF_DEPTH))) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // A redirect cancels the request even if granted now.
                if (redirect) begin
                    state_d = IDLE;
                end else if (imem_gnt) begin
                    state_d  = WAIT;
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                end
            end
            WAIT: begin
                if (redirect) begin
                    state_d = imem_rvalid ? IDLE : DROP;
                end else if (imem_rvalid) begin
                    buf_push = 1'b1;
                    state_d  = IDLE;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect) begin
            pc_d = align_word(redirect_pc);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    assign imem_req  = (state_q == REQ);
    assign imem_addr = pc_q;

    assign push_entry = '{instr: imem_rdata, pc: req_pc_q};
    assign buf_pop    = id_valid && id_ready && !redirect;

    instr_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (buf_push),
        .pop_i   (buf_pop),
        .flush_i (redirect),
        .wdata_i (push_entry),
        .rdata_o (head),
        .count_o (buf_count)
    );

    assign id_valid = (buf_count != '0);
    assign id_instr = id_valid ? head.instr : NOP_INSTR;
    assign id_pc    = id_valid ? head.pc : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit.
// Reference: a queue of expected buffered PCs plus a memory responder.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (RPC),
        .BUF_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc)
    );

    int n_pass = 0;
    int n_chk = 0;

    // Reference state: buffered PCs, next fetch PC, in-flight request.
    logic [31:0] mq[$];
    logic [31:0] m_pc;
    bit          busy;
    bit          killed;
    logic [31:0] o_addr;
    int          dly;

    int p_gnt, p_ready, p_redir, p_spur, min_dly, max_dly;
    bit          f_redir;
    logic [31:0] f_pc;
    bit          f_ready_en;
    bit          req_s;
    logic [31:0] addr_s;
    bit          redir_req_prev;
    bit          pop_now;
    bit          dut_pop;
    logic [31:0] dut_pc_s;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return 32'h0050_0093 ^ {a[24:0], 7'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        n_chk++;
        assert (o === e) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        chk("id_valid", id_valid, 32'(mq.size() != 0));
        chk("id_instr", id_instr, (mq.size() != 0) ? mem_f(mq[0]) : NOP);
        chk("id_pc", id_pc, (mq.size() != 0) ? mq[0] : 32'd0);
        if (redir_req_prev) chk("req_cancel", imem_req, 0);
        req_s  = imem_req;
        addr_s = imem_addr;
        if (imem_req) begin
            chk("imem_addr", imem_addr, m_pc);
            chk("one_outstanding", 32'(busy), 0);
        end
        imem_gnt = ($urandom_range(0, 99) < p_gnt);
        if (busy && dly == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_f(o_addr);
        end else if (!busy && $urandom_range(0, 99) < p_spur) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        if (f_redir) begin
            redirect    = 1'b1;
            redirect_pc = f_pc;
            f_redir     = 1'b0;
        end else begin
            redirect    = ($urandom_range(0, 99) < p_redir);
            redirect_pc = $urandom;
        end
        if (f_ready_en) begin
            id_ready   = 1'b1;
            f_ready_en = 1'b0;
        end else begin
            id_ready = ($urandom_range(0, 99) < p_ready);
        end
        pop_now  = (mq.size() != 0) && id_ready && !redirect;
        dut_pop  = id_valid && id_ready && !redirect;
        dut_pc_s = id_pc;
        @(posedge clk);
        if (redirect) begin
            mq.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
            if (busy) killed = 1'b1;
        end else begin
            if (pop_now) void'(mq.pop_front());
            if (busy && imem_rvalid && !killed) begin
                mq.push_back(o_addr);
                chk("buf_cap", 32'(mq.size() <= 2), 1);
            end
        end
        if (busy) begin
            if (imem_rvalid) busy = 1'b0;
            else if (dly > 0) dly--;
        end else if (req_s && imem_gnt && !redirect) begin
            busy   = 1'b1;
            killed = 1'b0;
            o_addr = m_pc;
            m_pc   = m_pc + 32'd4;
            dly    = $urandom_range(min_dly, max_dly);
        end
        redir_req_prev = redirect && req_s;
    endtask

    task automatic do_reset(input bit stale);
        @(negedge clk);
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b0;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_valid", id_valid, 0);
        chk("rst_instr", id_instr, NOP);
        chk("rst_pc", id_pc, 0);
        mq.delete();
        m_pc = RPC;
        busy = 1'b0;
        killed = 1'b0;
        redir_req_prev = 1'b0;
        repeat (2) @(negedge clk);
        rst_n       = 1'b1;
        imem_rvalid = stale;
        imem_rdata  = 32'hDEAD_BEEF;
    endtask

    task automatic knobs(input int g, input int r, input int d,
                         input int s, input int lo, input int hi);
        p_gnt = g; p_ready = r; p_redir = d;
        p_spur = s; min_dly = lo; max_dly = hi;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          found;
        int          n;
        int          first_c;
        int          last_c;
        logic [31:0] exp_pc;

        f_redir = 1'b0;
        f_ready_en = 1'b0;
        knobs(100, 0, 0, 0, 0, 0);
        do_reset(1'b0);

        // first fetch: grant at once, data next cycle
        repeat (2) cycle();
        #1;
        chk("first_valid", id_valid, 1);
        chk("first_instr", id_instr, 32'h0050_0093);
        chk("first_pc", id_pc, RPC);

        // decode stalled: buffer fills to two and fetching stops
        repeat (10) cycle();
        #1;
        chk("stall_req", imem_req, 0);
        chk("stall_head_pc", id_pc, RPC);
        chk("stall_head_instr", id_instr, 32'h0050_0093);
        p_ready = 100;
        cycle();
        #1;
        chk("second_pc", id_pc, RPC + 32'd4);

        // redirect while waiting for data
        knobs(100, 100, 0, 0, 2, 2);
        for (int i = 0; i < 20 && !busy; i++) cycle();
        chk("reach_wait", 32'(busy), 1);
        f_redir = 1'b1;
        f_pc = 32'h0000_0102;
        cycle();
        #1;
        chk("redir_valid", id_valid, 0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            found = req_s;
        end
        chk("redir_found", 32'(found), 1);
        chk("redir_addr", addr_s, 32'h0000_0100);

        // redirect, rvalid and pop together
        knobs(100, 100, 0, 0, 0, 0);
        repeat (4) cycle();
        p_ready = 0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            found = (mq.size() == 1) && busy && (dly == 0);
        end
        chk("combo_setup", 32'(found), 1);
        f_redir = 1'b1;
        f_pc = 32'h0000_0A40;
        f_ready_en = 1'b1;
        cycle();
        #1;
        chk("combo_valid", id_valid, 0);
        chk("combo_instr", id_instr, NOP);
        chk("combo_pc", id_pc, 0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            found = req_s;
        end
        chk("combo_found", 32'(found), 1);
        chk("combo_addr", addr_s, 32'h0000_0A40);

        // reset in the middle of a transaction, then stale data
        knobs(100, 0, 0, 0, 2, 2);
        for (int i = 0; i < 20 && !busy; i++) cycle();
        chk("rst_wait", 32'(busy), 1);
        do_reset(1'b1);
        cycle();
        #1;
        chk("stale_valid", id_valid, 0);
        repeat (6) cycle();

        // randomized traffic
        for (int b = 0; b < 15; b++) begin
            knobs($urandom_range(20, 100), $urandom_range(10, 100),
                  $urandom_range(0, 15), $urandom_range(0, 30),
                  0, $urandom_range(0, 3));
            repeat (200) cycle();
        end

        // streaming: one instruction every three cycles
        knobs(100, 100, 0, 0, 0, 0);
        do_reset(1'b0);
        exp_pc = RPC;
        n = 0;
        first_c = 0;
        last_c = 0;
        for (int c = 0; c < 400 && n < 100; c++) begin
            cycle();
            if (dut_pop) begin
                chk("stream_pc", dut_pc_s, exp_pc);
                exp_pc = exp_pc + 32'd4;
                if (n == 0) first_c = c;
                last_c = c;
                n++;
            end
        end
        chk("stream_count", n, 100);
        chk("stream_span", last_c - first_c, 297);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
